// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions/interrupts of the memory-stage
// instruction, owns the M-mode trap CSRs, and drives the redirect pulse plus flush window.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_instr,
    input  logic        mem_ecall,
    input  logic        mem_ebreak,
    input  logic        mem_illegal,
    input  logic        mem_mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        mret_taken,
    output logic [31:0] trap_pc,
    output logic        flush,
    output logic [31:0] mstatus,
    output logic [31:0] mepc,
    output logic [31:0] mcause
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic        meie_q, meie_d, mtie_q, mtie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        is_mret_q, is_mret_d;

    logic        sample, trap_evt, mret_evt, is_irq;
    logic [3:0]  code;
    logic [31:0] tval, mip_v, mstatus_v, trap_base;

    assign sample    = (state_q == S_IDLE) && mem_valid;
    assign mip_v     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
    assign mstatus_v = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign trap_base = {mtvec_q[31:2], 2'b00};

    // Cause selection in priority order; interrupts need both the enable and global MIE.
    always_comb begin
        trap_evt = 1'b1;
        is_irq   = 1'b0;
        code     = 4'd0;
        tval     = 32'b0;
        if (irq_ext && meie_q && mst_mie_q) begin
            is_irq = 1'b1;
            code   = 4'd11;
        end else if (irq_timer && mtie_q && mst_mie_q) begin
            is_irq = 1'b1;
            code   = 4'd7;
        end else if (mem_illegal) begin
            code = 4'd2;
            tval = mem_instr;
        end else if (mem_ecall) begin
            code = 4'd11;
        end else if (mem_ebreak) begin
            code = 4'd3;
            tval = mem_pc;
        end else begin
            trap_evt = 1'b0;
        end
        mret_evt = mem_mret && !trap_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:     if (sample && (trap_evt || mret_evt)) state_d = S_REDIRECT;
            S_REDIRECT: begin
                cnt_d   = FLUSH_LOAD;
                state_d = (FLUSH_CYCLES <= 1) ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trap_taken = (state_q == S_REDIRECT) && !is_mret_q;
        mret_taken = (state_q == S_REDIRECT) && is_mret_q;
        flush      = (state_q == S_REDIRECT) || ((state_q == S_FLUSH) && (cnt_q != 4'd0));
    end

    // CSR write lands first; trap/MRET field updates then override it on the same edge.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        trap_pc_d  = trap_pc_q;
        is_mret_d  = is_mret_q;
        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                end
                CSR_MIE: begin
                    meie_d = csr_wdata[11];
                    mtie_d = csr_wdata[7];
                end
                CSR_MTVEC:  mtvec_d  = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
                CSR_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                CSR_MTVAL:  mtval_d  = csr_wdata;
                default:    ;
            endcase
        end
        if (sample && trap_evt) begin
            mepc_d     = mem_pc;
            mcause_d   = {is_irq, 27'b0, code};
            mtval_d    = tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            is_mret_d  = 1'b0;
            trap_pc_d  = (mtvec_q[0] && is_irq) ? trap_base + {26'b0, code, 2'b00} : trap_base;
        end else if (sample && mret_evt) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            is_mret_d  = 1'b1;
            trap_pc_d  = mepc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= 32'b0;
            mcause_q   <= 32'b0;
            mtval_q    <= 32'b0;
            trap_pc_q  <= 32'b0;
            is_mret_q  <= 1'b0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            trap_pc_q  <= trap_pc_d;
            is_mret_q  <= is_mret_d;
        end
    end

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus_v;
            CSR_MIE:     csr_rdata = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MTVAL:   csr_rdata = mtval_q;
            CSR_MIP:     csr_rdata = mip_v;
            default:     csr_rdata = 32'b0;
        endcase
    end

    assign trap_pc = trap_pc_q;
    assign mstatus = mstatus_v;
    assign mepc    = mepc_q;
    assign mcause  = mcause_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected redirects are queued at issue time and
// checked by a monitor whenever trap_taken or mret_taken pulses.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_ecall, mem_ebreak, mem_illegal, mem_mret;
    logic [31:0] mem_pc, mem_instr;
    logic        irq_ext, irq_timer, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, trap_pc, mstatus, mepc, mcause;
    logic        trap_taken, mret_taken, flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_mret;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] status;
    } exp_t;
    exp_t exp_q[$];

    trap_ctrl #(.MTVEC_RESET(32'h0000_0100), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_instr(mem_instr), .mem_ecall(mem_ecall), .mem_ebreak(mem_ebreak),
        .mem_illegal(mem_illegal), .mem_mret(mem_mret), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_taken(trap_taken),
        .mret_taken(mret_taken), .trap_pc(trap_pc), .flush(flush),
        .mstatus(mstatus), .mepc(mepc), .mcause(mcause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] pc, cause, epc, status);
        exp_t e;
        e.is_mret = m; e.pc = pc; e.cause = cause; e.epc = epc; e.status = status;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic issue(input logic [31:0] pc, instr, input logic ec, eb, il, mr, ie, it);
        mem_valid = 1'b1; mem_pc = pc; mem_instr = instr;
        mem_ecall = ec; mem_ebreak = eb; mem_illegal = il; mem_mret = mr;
        irq_ext = ie; irq_timer = it;
        tick();
        mem_valid = 1'b0; mem_ecall = 1'b0; mem_ebreak = 1'b0; mem_illegal = 1'b0;
        mem_mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    // Monitor: every redirect pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (trap_taken || mret_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got trap=%b mret=%b pc=%h expected none",
                             trap_taken, mret_taken, trap_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn %s pc=%h mcause=%h mepc=%h mstatus=%h",
                             mret_taken ? "mret" : "trap", trap_pc, mcause, mepc, mstatus);
                    chk("redirect_kind", {30'b0, trap_taken, mret_taken}, {30'b0, !e.is_mret, e.is_mret});
                    chk("trap_pc", trap_pc, e.pc);
                    chk("mcause", mcause, e.cause);
                    chk("mepc", mepc, e.epc);
                    chk("mstatus", mstatus, e.status);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fl;
        reset_n = 1'b0; mem_valid = 1'b0; mem_pc = '0; mem_instr = '0;
        mem_ecall = 1'b0; mem_ebreak = 1'b0; mem_illegal = 1'b0; mem_mret = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        #12;
        chk("reset_mstatus", mstatus, 32'h0000_1800);
        chk("reset_mepc", mepc, 32'h0);
        chk("reset_pulses", {30'b0, trap_taken, mret_taken}, 32'h0);
        chk("reset_flush", {31'b0, flush}, 32'h0);
        csr_rd("reset_mtvec", 12'h305, 32'h0000_0100);
        reset_n = 1'b1;
        tick();

        // ECALL with MIE=1, then MRET back
        csr_wr(12'h300, 32'h0000_0008);
        chk("mstatus_write", mstatus, 32'h0000_1808);
        push(1'b0, 32'h100, 32'd11, 32'h40, 32'h0000_1880);
        issue(32'h40, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fl = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (flush) fl++;
        end
        chk("flush_cycles", 32'(fl), 32'd3);
        push(1'b1, 32'h40, 32'd11, 32'h40, 32'h0000_1888);
        issue(32'h104, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();

        // vectored external interrupt; irq without mem_valid must not trap
        csr_wr(12'h305, 32'h0000_0201);
        csr_wr(12'h304, 32'h0000_0800);
        irq_ext = 1'b1;
        csr_rd("mip_ext", 12'h344, 32'h0000_0800);
        tick();
        irq_ext = 1'b0;
        push(1'b0, 32'h22C, 32'h8000_000B, 32'h80, 32'h0000_1880);
        issue(32'h80, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        push(1'b1, 32'h80, 32'h8000_000B, 32'h80, 32'h0000_1888);
        issue(32'h208, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();

        // timer beats illegal when enabled; with MIE=0 illegal is taken
        csr_wr(12'h304, 32'h0000_0880);
        push(1'b0, 32'h21C, 32'h8000_0007, 32'h90, 32'h0000_1880);
        issue(32'h90, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        push(1'b0, 32'h200, 32'd2, 32'hA0, 32'h0000_1800);
        issue(32'hA0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        csr_rd("mtval_illegal", 12'h343, 32'hDEAD_BEEF);

        // EBREAK records its PC in mtval
        csr_wr(12'h305, 32'h0000_0100);
        push(1'b0, 32'h100, 32'd3, 32'hB4, 32'h0000_1800);
        issue(32'hB4, 32'h0010_0073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        csr_rd("mtval_ebreak", 12'h343, 32'h0000_00B4);

        // ECALLs during redirect/flush are ignored
        csr_wr(12'h300, 32'h0000_0008);
        push(1'b0, 32'h100, 32'd11, 32'h40, 32'h0000_1880);
        issue(32'h40, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_valid = 1'b1; mem_ecall = 1'b1; mem_pc = 32'h44;
        repeat (3) tick();
        mem_valid = 1'b0; mem_ecall = 1'b0;
        tick(); tick();
        chk("mepc_after_ignored", mepc, 32'h40);

        // CSR write to mepc on the same edge as a trap loses
        csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h1234_5677;
        push(1'b0, 32'h100, 32'd11, 32'h50, 32'h0000_1800);
        issue(32'h50, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        csr_we = 1'b0;
        settle();
        csr_wr(12'h341, 32'h1234_5677);
        chk("mepc_write_align", mepc, 32'h1234_5674);
        csr_wr(12'h7C0, 32'hFFFF_FFFF);
        csr_rd("unmapped_read", 12'h7C0, 32'h0);

        // reset in the middle of the flush window
        csr_wr(12'h305, 32'h0000_0300);
        push(1'b0, 32'h300, 32'd11, 32'h60, 32'h0000_1800);
        issue(32'h60, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #3;
        chk("flush_before_reset", {31'b0, flush}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("flush_reset", {31'b0, flush}, 32'h0);
        chk("mcause_reset", mcause, 32'h0);
        csr_rd("mtvec_reset", 12'h305, 32'h0000_0100);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        push(1'b0, 32'h100, 32'd11, 32'h70, 32'h0000_1800);
        issue(32'h70, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
